// File: rtl/convert_dec_2_bi.sv
// convert_dec_2_bi: serial decimal (floor + F/10^D) to IEEE-754 single conversion.
// Streams integer bits MSB first, then fraction bits by repeated doubling, then rounds to nearest-even.
module convert_dec_2_bi (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_sign,
    input  logic [31:0] in_floor,
    input  logic [31:0] in_frac,
    input  logic [3:0]  in_frac_dig,
    output logic [31:0] out,
    output logic        busy,
    output logic        done,
    output logic        err
);
    typedef enum logic [2:0] {IDLE, INT, FRAC, ROUND, DONE, ERR} state_t;

    state_t             state_q, state_d;
    logic               sign_q, sign_d;
    logic [31:0]        floor_q, floor_d;
    logic [31:0]        f_q, f_d;
    logic [3:0]         d_q, d_d;
    logic [6:0]         cnt_q, cnt_d;
    logic               found_q, found_d;
    logic [4:0]         nsig_q, nsig_d;
    logic [23:0]        sig_q, sig_d;
    logic               r_q, r_d;
    logic               s_q, s_d;
    logic signed [7:0]  exp_q, exp_d;
    logic [31:0]        out_q, out_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [31:0]        pow, f2;
    logic               bit_b, illegal, rnd;
    logic [24:0]        sum;
    logic signed [7:0]  exp_r;
    logic [7:0]         biased;

    function automatic logic [31:0] pow10(input logic [3:0] d);
        case (d)
            4'd0:    pow10 = 32'd1;
            4'd1:    pow10 = 32'd10;
            4'd2:    pow10 = 32'd100;
            4'd3:    pow10 = 32'd1000;
            4'd4:    pow10 = 32'd10000;
            4'd5:    pow10 = 32'd100000;
            4'd6:    pow10 = 32'd1000000;
            4'd7:    pow10 = 32'd10000000;
            4'd8:    pow10 = 32'd100000000;
            4'd9:    pow10 = 32'd1000000000;
            default: pow10 = 32'hFFFF_FFFF;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        floor_d = floor_q;
        f_d     = f_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        found_d = found_q;
        nsig_d  = nsig_q;
        sig_d   = sig_q;
        r_d     = r_q;
        s_d     = s_q;
        exp_d   = exp_q;
        out_d   = out_q;
        done_d  = 1'b0;
        err_d   = err_q;
        pow     = pow10(d_q);
        f2      = f_q << 1;
        bit_b   = (state_q == INT) ? floor_q[31] : (f2 >= pow);
        illegal = (in_frac_dig > 4'd9) || (in_frac >= pow10(in_frac_dig));
        rnd     = r_q & (s_q | (f_q != 32'd0) | sig_q[0]);
        sum     = {1'b0, sig_q} + {24'd0, rnd};
        exp_r   = exp_q + (sum[24] ? 8'sd1 : 8'sd0);
        biased  = exp_r + 8'sd127;
        // Leading one, 23 more significand bits, round bit, then everything else is sticky.
        if (state_q == INT || state_q == FRAC) begin
            cnt_d = cnt_q + 7'd1;
            if (!found_q) begin
                if (bit_b) begin
                    found_d = 1'b1;
                    nsig_d  = 5'd1;
                    sig_d   = 24'd1;
                    exp_d   = 8'sd31 - $signed({1'b0, cnt_q});
                end
            end else if (nsig_q < 5'd24) begin
                sig_d  = {sig_q[22:0], bit_b};
                nsig_d = nsig_q + 5'd1;
            end else if (nsig_q == 5'd24) begin
                r_d    = bit_b;
                nsig_d = 5'd25;
            end else begin
                s_d = s_q | bit_b;
            end
        end
        case (state_q)
            IDLE: if (start) begin
                sign_d  = in_sign;
                floor_d = in_floor;
                f_d     = in_frac;
                d_d     = in_frac_dig;
                cnt_d   = 7'd0;
                found_d = 1'b0;
                nsig_d  = 5'd0;
                sig_d   = 24'd0;
                r_d     = 1'b0;
                s_d     = 1'b0;
                exp_d   = 8'sd0;
                state_d = illegal ? ERR : INT;
            end
            ERR: begin
                done_d  = 1'b1;
                err_d   = 1'b1;
                out_d   = 32'd0;
                state_d = IDLE;
            end
            INT: begin
                floor_d = floor_q << 1;
                if (cnt_q == 7'd31)
                    state_d = (nsig_d == 5'd25 || (!found_d && f_q == 32'd0)) ? ROUND : FRAC;
            end
            FRAC: begin
                f_d = bit_b ? f2 - pow : f2;
                if (nsig_d == 5'd25)
                    state_d = ROUND;
            end
            ROUND: begin
                done_d  = 1'b1;
                err_d   = 1'b0;
                out_d   = found_q ? {sign_q, biased, sum[24] ? 23'd0 : sum[22:0]} : {sign_q, 31'd0};
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            floor_q <= 32'd0;
            f_q     <= 32'd0;
            d_q     <= 4'd0;
            cnt_q   <= 7'd0;
            found_q <= 1'b0;
            nsig_q  <= 5'd0;
            sig_q   <= 24'd0;
            r_q     <= 1'b0;
            s_q     <= 1'b0;
            exp_q   <= 8'sd0;
            out_q   <= 32'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            floor_q <= floor_d;
            f_q     <= f_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            found_q <= found_d;
            nsig_q  <= nsig_d;
            sig_q   <= sig_d;
            r_q     <= r_d;
            s_q     <= s_d;
            exp_q   <= exp_d;
            out_q   <= out_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign out  = out_q;
    assign done = done_q;
    assign err  = err_q;
    assign busy = (state_q == INT) || (state_q == FRAC) || (state_q == ROUND) || (state_q == ERR);
endmodule

// File: tb/tb_convert_dec_2_bi.sv
// tb_convert_dec_2_bi: directed checks of value, latency, error, busy-start and reset behaviour.
module tb_convert_dec_2_bi;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_sign = 1'b0;
    logic [31:0] in_floor = 32'd0;
    logic [31:0] in_frac = 32'd0;
    logic [3:0]  in_frac_dig = 4'd0;
    logic [31:0] out;
    logic        busy, done, err;
    int          checks = 0;
    int          errors = 0;

    convert_dec_2_bi dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_sign(in_sign),
        .in_floor(in_floor), .in_frac(in_frac), .in_frac_dig(in_frac_dig),
        .out(out), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    task automatic conv(input string tag, input logic s, input logic [31:0] fl, input logic [31:0] fr,
                        input logic [3:0] d, input logic [31:0] eout, input logic eerr, input int elat,
                        input bit poke);
        int lat;
        bit seen;
        @(negedge clk);
        in_sign = s; in_floor = fl; in_frac = fr; in_frac_dig = d; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        in_sign = ~s; in_floor = $urandom; in_frac = $urandom; in_frac_dig = 4'($urandom);
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 200) begin
            start = (poke && lat == 5);
            @(posedge clk);
            #1;
            lat++;
            seen = done;
        end
        start = 1'b0;
        chk({tag, "_lat"}, 32'(lat), 32'(elat));
        chk({tag, "_out"}, out, eout);
        chk({tag, "_err"}, {31'd0, err}, {31'd0, eerr});
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_hold"}, out, eout);
    endtask

    initial begin
        int dcount;
        #1;
        chk("rst_out", out, 32'd0);
        chk("rst_flags", {29'd0, busy, done, err}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        conv("two",      1'b0, 32'd2,   32'd0, 4'd0, 32'h4000_0000, 1'b0, 56, 1'b0);
        conv("three_6",  1'b0, 32'd3,   32'd6, 4'd1, 32'h4066_6666, 1'b0, 56, 1'b0);
        conv("h100_2",   1'b0, 32'd100, 32'd2, 4'd1, 32'h42C8_6666, 1'b0, 51, 1'b0);
        conv("zero_2",   1'b0, 32'd0,   32'd2, 4'd1, 32'h3E4C_CCCD, 1'b0, 60, 1'b0);
        conv("z_0002",   1'b0, 32'd0,   32'd2, 4'd4, 32'h3951_B717, 1'b0, 70, 1'b0);
        conv("neg56",    1'b1, 32'd56,  32'd2, 4'd4, 32'hC260_0034, 1'b0, 52, 1'b0);
        conv("negzero",  1'b1, 32'd0,   32'd0, 4'd3, 32'h8000_0000, 1'b0, 33, 1'b0);
        conv("d10",      1'b0, 32'd5,   32'd0, 4'd10, 32'd0,        1'b1, 1,  1'b0);
        conv("poszero",  1'b0, 32'd0,   32'd0, 4'd5, 32'h0000_0000, 1'b0, 33, 1'b0);
        conv("f10",      1'b0, 32'd5,   32'd10, 4'd1, 32'd0,        1'b1, 1,  1'b0);
        conv("maxint",   1'b0, 32'hFFFF_FFFF, 32'd0, 4'd0, 32'h4F80_0000, 1'b0, 33, 1'b0);
        conv("busy_st",  1'b0, 32'd3,   32'd6, 4'd1, 32'h4066_6666, 1'b0, 56, 1'b1);
        @(negedge clk);
        in_sign = 1'b0; in_floor = 32'd0; in_frac = 32'd2; in_frac_dig = 4'd1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (39) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out", out, 32'd0);
        chk("abort_flags", {29'd0, busy, done, err}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            dcount += int'(done);
        end
        chk("abort_nodone", 32'(dcount), 32'd0);
        conv("after_rst", 1'b0, 32'd3, 32'd6, 4'd1, 32'h4066_6666, 1'b0, 56, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/convert_dec_2_bi.md
CONVERT_DEC_2_BI -- requirements
Module: convert_dec_2_bi

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  conversion request, sampled only in IDLE.
REQ-005 in_sign  input  1  sign of the decimal value (1 = negative).
REQ-006 in_floor  input  32  unsigned integer part, binary.
REQ-007 in_frac  input  32  fractional numerator F, binary; fraction = F / 10^D.
REQ-008 in_frac_dig  input  4  fractional digit count D, legal range 0..9.
REQ-009 out  output  32  IEEE-754 single-precision result.
REQ-010 busy  output  1  high from the cycle after start is accepted until done.
REQ-011 done  output  1  one-cycle pulse; out and err are valid in that cycle.
REQ-012 err  output  1  illegal input flag, valid with done.

Function
REQ-013 States SHALL be IDLE, INT, FRAC, ROUND, DONE and ERR.
REQ-014 In IDLE with start=1 at edge T0, all inputs SHALL be latched; later input changes SHALL have no effect.
REQ-015 Illegal latched input (D>9, or F >= 10^D) SHALL go to ERR; at edge T0+1: done=1, err=1, out=0; next state IDLE.
REQ-016 INT SHALL last exactly 32 cycles and stream in_floor bits MSB first, one bit per cycle.
REQ-017 FRAC SHALL produce one fraction bit per cycle: F <= 2F; bit=1 and F <= F - 10^D when 2F >= 10^D; 10^D comes from a 10-entry constant table.
REQ-018 The first 1 in the combined stream is the leading one; the leading one plus the next 23 bits form the 24-bit significand, the following bit is the round bit R, and all later bits OR into sticky S.
REQ-019 After FRAC ends, S SHALL additionally OR in (F != 0).
REQ-020 Unbiased exponent SHALL be i for a leading one at integer bit i, and -k for fraction bit k (1-based).
REQ-021 The biased exponent range is 97..158, so overflow and denormals cannot occur.
REQ-022 FRAC SHALL run N cycles, where N = max(0, 24-i) for an integer leading one and N = k+24 for a fraction leading one.
REQ-023 If no leading one is found by the end of INT and F==0 (zero input), FRAC SHALL be skipped; the output is out={in_sign,31'b0}.
REQ-024 ROUND SHALL apply round-to-nearest-even: increment the significand when R & (S | lsb).
REQ-025 A carry out of the 24-bit significand SHALL increment the exponent and clear the mantissa.
REQ-026 out SHALL be {in_sign, exp+127, mantissa[22:0]}, registered on the edge entering DONE; done=1 for exactly that one cycle; next state IDLE.
REQ-027 Latency from start edge T0 to done SHALL be 33+N cycles, with N=0 for zero input.
REQ-028 out SHALL hold its value until the next done.
REQ-029 start while busy SHALL be ignored.
REQ-030 start in the DONE cycle SHALL be ignored; a new start is accepted only in IDLE.
REQ-031 Arithmetic widths: F and 2F SHALL be held in 32 bits, since 2*10^9 < 2^32.
REQ-032 The collection counter and exponent SHALL be held in at least 7 bits signed.

Reset
REQ-033 rst_n low SHALL immediately force state=IDLE, out=0, busy=0, done=0, err=0, and clear all internal registers.
REQ-034 Reset asserted mid-conversion SHALL abort the conversion with no done pulse.
REQ-035 After rst_n deasserts, the first start SHALL be accepted normally.

Verification
REQ-036 floor=2, F=0, D=0, sign=0 -> out=0x40000000, done at T0+56, err=0.
REQ-037 floor=3, F=6, D=1 -> out=0x40666666. floor=100, F=2, D=1 -> out=0x42C86666.
REQ-038 floor=0, F=2, D=1 -> out=0x3E4CCCCD at T0+60 (rounding up). floor=0, F=2, D=4 -> out=0x3951B717 at T0+70.
REQ-039 floor=56, F=2, D=4, sign=1 -> out=0xC2600034. Zero input with sign=1 -> out=0x80000000 at T0+33.
REQ-040 D=10, or F=10, D=1 -> done and err at T0+1, out=0. start pulsed while busy -> no effect on the result.
REQ-041 rst_n low at T0+40 during 0.2 conversion -> outputs zero immediately, no done. A following 3.6 conversion -> 0x40666666.
